// File: rtl/shiftright_grs_pipe_if.sv
// ---------------------------------------------------------------------------
// shiftright_grs_pipe_if
//
// Bundle of the streaming ports of the GRS right shifter.
//   in_valid / in_ready   : input handshake, beat accepted on both high
//   in_data               : mantissa to shift (WIDTH bits)
//   in_nshift             : right-shift amount (SHW bits)
//   out_valid / out_ready : output handshake, beat transferred on both high
//   out_data              : shifted mantissa, zero-filled from the MSB
//   out_guard             : first bit shifted out below the mantissa LSB
//   out_round             : second bit shifted out below the mantissa LSB
//   out_sticky            : OR of every bit shifted out below the round bit
//
// Modports:
//   slave  : the shifter itself
//   master : the producer/consumer environment driving the shifter
// ---------------------------------------------------------------------------
interface shiftright_grs_pipe_if #(
    parameter int WIDTH = 24,
    parameter int SHW   = 5
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_nshift;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_guard;
    logic             out_round;
    logic             out_sticky;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_nshift,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_guard,
        output out_round,
        output out_sticky
    );

    modport master (
        output in_valid,
        output in_data,
        output in_nshift,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_guard,
        input  out_round,
        input  out_sticky
    );

endinterface

// File: rtl/shiftright_grs_pipe.sv
// ---------------------------------------------------------------------------
// shiftright_grs_pipe
//
// Pipelined logarithmic right shifter producing an aligned mantissa plus the
// guard, round and sticky bits consumed by the rounding stage.
//
// Every beat travels as an extended word {data, g, r} with a separate sticky
// flag.  Stage k shifts right by 2^(SHW-1-k) when the matching shift-amount
// bit is set (largest step first), ORing every bit that falls off below r
// into sticky.  One register stage per shift-amount bit, so the latency is
// SHW cycles; each stage has its own valid flag so bubbles compact under
// backpressure and the pipeline sustains one beat per cycle.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; drops every in-flight beat and
//          clears the output registers
//   bus  : shiftright_grs_pipe_if.slave (input/output handshakes and data)
//
// SHW must be at least 2.
// ---------------------------------------------------------------------------
module shiftright_grs_pipe #(
    parameter int WIDTH = 24,
    parameter int SHW   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    shiftright_grs_pipe_if.slave  bus
);

    // Extended word: mantissa followed by guard and round positions.
    localparam int EW = WIDTH + 2;

    // Shift an extended word right by amt; result is {shifted_word, lost}
    // where lost is the OR of every bit pushed out below position 0.  An
    // amount at or beyond EW clears the word and reports every bit as lost.
    function automatic logic [EW:0] shift_ext(input logic [EW-1:0] ext,
                                              input int unsigned   amt);
        logic [EW-1:0] one_v;
        logic [EW-1:0] mask_v;
        logic [EW-1:0] shifted_v;
        logic          lost_v;
        one_v     = {{(EW-1){1'b0}}, 1'b1};
        mask_v    = (one_v << amt) - one_v;
        shifted_v = ext >> amt;
        lost_v    = |(ext & mask_v);
        return {shifted_v, lost_v};
    endfunction

    // Stage registers.  nsh_r only exists for stages that feed another
    // stage; the last stage has no shift bits left to consume.
    logic [SHW-1:0]            valid_r;
    logic [SHW-1:0][EW-1:0]    ext_r;
    logic [SHW-1:0]            sticky_r;
    logic [SHW-2:0][SHW-1:0]   nsh_r;

    // Per-stage source (upstream register or module input) and next value.
    logic [SHW-1:0]            ready_s;
    logic [SHW-1:0]            src_valid_s;
    logic [SHW-1:0][EW-1:0]    src_ext_s;
    logic [SHW-1:0]            src_sticky_s;
    logic [SHW-1:0][SHW-1:0]   src_nsh_s;
    logic [SHW-1:0][EW-1:0]    nxt_ext_s;
    logic [SHW-1:0]            nxt_sticky_s;

    // Stage k's source is stage k-1; stage 0 takes the input beat with
    // g, r and sticky cleared.
    assign src_valid_s  = {valid_r[SHW-2:0], bus.in_valid};
    assign src_ext_s    = {ext_r[SHW-2:0], {bus.in_data, 2'b00}};
    assign src_sticky_s = {sticky_r[SHW-2:0], 1'b0};
    assign src_nsh_s    = {nsh_r[SHW-2:0], bus.in_nshift};

    // Stage k may load when it is empty or when every stage from k to the
    // output is full and the consumer is taking the head beat.  Written as
    // a suffix-AND of valid flags so there is no path from in_valid.
    always_comb begin
        logic tail_full_v;
        ready_s     = '0;
        tail_full_v = 1'b1;
        for (int k = SHW - 1; k >= 0; k--) begin
            tail_full_v = tail_full_v & valid_r[k];
            ready_s[k]  = bus.out_ready | ~tail_full_v;
        end
    end

    // Conditional 2^(SHW-1-k) shift of each stage's source beat.
    always_comb begin
        logic [EW:0] shift_v;
        nxt_ext_s    = '0;
        nxt_sticky_s = '0;
        shift_v      = '0;
        for (int k = 0; k < SHW; k++) begin
            shift_v = shift_ext(src_ext_s[k], 32'd1 << (SHW - 1 - k));
            if (src_nsh_s[k][SHW-1-k]) begin
                nxt_ext_s[k]    = shift_v[EW:1];
                nxt_sticky_s[k] = src_sticky_s[k] | shift_v[0];
            end else begin
                nxt_ext_s[k]    = src_ext_s[k];
                nxt_sticky_s[k] = src_sticky_s[k];
            end
        end
    end

    // Stage valid flags and payload registers; payload loads only when a
    // beat actually advances into the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r  <= '0;
            ext_r    <= '0;
            sticky_r <= '0;
            nsh_r    <= '0;
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (ready_s[k]) begin
                    valid_r[k] <= src_valid_s[k];
                    if (src_valid_s[k]) begin
                        ext_r[k]    <= nxt_ext_s[k];
                        sticky_r[k] <= nxt_sticky_s[k];
                    end
                end
            end
            for (int k = 0; k < SHW - 1; k++) begin
                if (ready_s[k] && src_valid_s[k]) begin
                    nsh_r[k] <= src_nsh_s[k];
                end
            end
        end
    end

    // Outputs come straight from the last stage registers.
    assign bus.in_ready   = ready_s[0];
    assign bus.out_valid  = valid_r[SHW-1];
    assign bus.out_data   = ext_r[SHW-1][EW-1:2];
    assign bus.out_guard  = ext_r[SHW-1][1];
    assign bus.out_round  = ext_r[SHW-1][0];
    assign bus.out_sticky = sticky_r[SHW-1];

    shiftright_grs_pipe_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .out_valid  (bus.out_valid),
        .out_ready  (bus.out_ready),
        .out_data   (bus.out_data),
        .out_guard  (bus.out_guard),
        .out_round  (bus.out_round),
        .out_sticky (bus.out_sticky)
    );

endmodule

// ---------------------------------------------------------------------------
// shiftright_grs_pipe_chk
//
// Protocol properties of the shifter output port: a stalled beat is held
// unchanged, and reset empties the output.
//   clk, rst                 : as for the shifter
//   out_valid .. out_sticky  : shifter output port, observed only
// ---------------------------------------------------------------------------
module shiftright_grs_pipe_chk #(
    parameter int WIDTH = 24
) (
    input logic             clk,
    input logic             rst,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] out_data,
    input logic             out_guard,
    input logic             out_round,
    input logic             out_sticky
);

    // A beat refused by the consumer stays valid and unchanged.
    property p_stall_hold;
        @(posedge clk) disable iff (rst)
            (out_valid && !out_ready) |=>
                (out_valid && $stable(out_data) && $stable(out_guard) &&
                 $stable(out_round) && $stable(out_sticky));
    endproperty
    a_stall_hold: assert property (p_stall_hold);

    // Reset leaves no beat at the output.
    property p_reset_empty;
        @(posedge clk) rst |=> !out_valid;
    endproperty
    a_reset_empty: assert property (p_reset_empty);

endmodule

// File: tb/tb_shiftright_grs_pipe.sv
// ---------------------------------------------------------------------------
// tb_shiftright_grs_pipe
//
// Directed bench for the GRS right shifter with hand-computed expectations:
// single beats (latency and GRS values), a stall/compaction sequence and a
// reset that drops in-flight beats.
// ---------------------------------------------------------------------------
module tb_shiftright_grs_pipe;

    localparam int WIDTH = 24;
    localparam int SHW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shiftright_grs_pipe_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    shiftright_grs_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    // Expected results for the stall sequence: 24'hFFFFFF >> n, n = 0..7.
    logic [23:0] bp_data [8] = '{24'hFFFFFF, 24'h7FFFFF, 24'h3FFFFF, 24'h1FFFFF,
                                 24'h0FFFFF, 24'h07FFFF, 24'h03FFFF, 24'h01FFFF};
    logic        bp_g    [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        bp_r    [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        bp_s    [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one beat into an otherwise empty pipeline and check latency + result.
    task automatic send_one(input string tag, input logic [23:0] d, input logic [4:0] n,
                            input logic [23:0] ed, input logic eg, input logic er,
                            input logic es);
        int lat;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_nshift = n;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat++;
        end while (!bus.out_valid && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_data"},    32'(bus.out_data),   32'(ed));
        check({tag, "_guard"},   32'(bus.out_guard),  32'(eg));
        check({tag, "_round"},   32'(bus.out_round),  32'(er));
        check({tag, "_sticky"},  32'(bus.out_sticky), 32'(es));
    endtask

    initial begin
        int acc;
        int rx;
        int extra;
        int stale;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_nshift = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("rst_out_data",   32'(bus.out_data),   32'd0);
        check("rst_out_guard",  32'(bus.out_guard),  32'd0);
        check("rst_out_round",  32'(bus.out_round),  32'd0);
        check("rst_out_sticky", 32'(bus.out_sticky), 32'd0);
        check("rst_in_ready",   32'(bus.in_ready),   32'd1);

        // Single beats
        send_one("n1",     24'h800000, 5'd1,  24'h400000, 1'b0, 1'b0, 1'b0);
        send_one("n4",     24'hFFFFFF, 5'd4,  24'h0FFFFF, 1'b1, 1'b1, 1'b1);
        send_one("n3",     24'h000005, 5'd3,  24'h000000, 1'b1, 1'b0, 1'b1);
        send_one("n0",     24'hABCDEF, 5'd0,  24'hABCDEF, 1'b0, 1'b0, 1'b0);
        send_one("n31",    24'h000001, 5'd31, 24'h000000, 1'b0, 1'b0, 1'b1);
        send_one("n24",    24'h800000, 5'd24, 24'h000000, 1'b1, 1'b0, 1'b0);
        send_one("n25",    24'hFFFFFF, 5'd25, 24'h000000, 1'b0, 1'b1, 1'b1);
        send_one("n26",    24'h000002, 5'd26, 24'h000000, 1'b0, 1'b0, 1'b1);
        send_one("n2",     24'h000003, 5'd2,  24'h000000, 1'b1, 1'b1, 1'b0);

        // Backpressure: fill with out_ready low
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 24'hFFFFFF;
            bus.in_nshift = 5'(acc);
            if (bus.in_ready) acc++;
            @(negedge clk);
        end
        check("bp_accepted",   32'(acc),            32'd5);
        check("bp_in_ready",   32'(bus.in_ready),   32'd0);
        check("bp_out_valid",  32'(bus.out_valid),  32'd1);
        check("bp_hold_data",  32'(bus.out_data),   32'hFFFFFF);
        check("bp_hold_guard", 32'(bus.out_guard),  32'd0);
        repeat (2) @(negedge clk);
        check("bp_hold2_data",   32'(bus.out_data),   32'hFFFFFF);
        check("bp_hold2_sticky", 32'(bus.out_sticky), 32'd0);
        check("bp_hold2_ready",  32'(bus.in_ready),   32'd0);

        // Release and drain, checking order and values
        bus.out_ready = 1'b1;
        #1;
        rx = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid && rx < 8) begin
                check($sformatf("bp_rx%0d_data", rx),   32'(bus.out_data),   32'(bp_data[rx]));
                check($sformatf("bp_rx%0d_guard", rx),  32'(bus.out_guard),  32'(bp_g[rx]));
                check($sformatf("bp_rx%0d_round", rx),  32'(bus.out_round),  32'(bp_r[rx]));
                check($sformatf("bp_rx%0d_sticky", rx), 32'(bus.out_sticky), 32'(bp_s[rx]));
                rx++;
            end
            if (acc < 8) begin
                bus.in_valid  = 1'b1;
                bus.in_data   = 24'hFFFFFF;
                bus.in_nshift = 5'(acc);
                if (bus.in_ready) acc++;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (rx == 8) break;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("bp_rx_count", 32'(rx),  32'd8);
        check("bp_tx_count", 32'(acc), 32'd8);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        check("bp_no_extra", 32'(extra), 32'd0);

        // Reset mid-operation
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_data   = 24'h123456;
            bus.in_nshift = 5'(b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("mid_rst_out_data",   32'(bus.out_data),   32'd0);
        check("mid_rst_out_guard",  32'(bus.out_guard),  32'd0);
        check("mid_rst_out_round",  32'(bus.out_round),  32'd0);
        check("mid_rst_out_sticky", 32'(bus.out_sticky), 32'd0);
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("mid_rst_no_stale", 32'(stale), 32'd0);
        send_one("post_rst", 24'hFFFFFF, 5'd4, 24'h0FFFFF, 1'b1, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
